req_arbiter10: RTL and testbench



---
 rtl/req_arbiter10_if.sv | 27 ++
 rtl/req_arbiter10.sv | 109 ++++++++++
 tb/tb_req_arbiter10.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/req_arbiter10_if.sv
// Request/grant bundle between ten requesters and the shared-encoder arbiter.
interface req_arbiter10_if;
    logic [9:0] req;   // bit k: requester k wants the resource
    logic       done;  // grantee releases the resource (single-cycle pulse)
    logic [9:0] gnt;   // one-hot grant or all-zero
    logic [3:0] idx;   // binary index of grantee, 4'hF when idle
    logic       busy;  // a grant is currently held
    logic       to;    // grant was revoked by timeout

    modport master (
        output req,
        output done,
        input  gnt,
        input  idx,
        input  busy,
        input  to
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output idx,
        output busy,
        output to
    );
endinterface

// File: rtl/req_arbiter10.sv
// Round-robin arbiter for ten requesters sharing one encoder. A grant is held
// until the grantee signals done, drops its request, or hits the timeout; each
// release is followed by a one-cycle gap before the next arbitration.
module req_arbiter10 #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst,
    req_arbiter10_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] gnt_q, gnt_d;
    logic [3:0] idx_q, idx_d;
    logic       to_q, to_d;

    logic [3:0] pick_idx;
    logic       holder_req;
    logic       timeout_hit;

    // First set bit at or above p, wrapping 9 -> 0; 4'hF if none.
    function automatic logic [3:0] pick_first(input logic [9:0] r, input logic [3:0] p);
        logic [3:0] res;
        logic [4:0] pos;
        logic       hit;
        res = 4'hF;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pos = 5'(p) + 5'(i);
            if (pos >= 5'd10) pos = pos - 5'd10;
            if (!hit && r[pos[3:0]]) begin
                hit = 1'b1;
                res = pos[3:0];
            end
        end
        return res;
    endfunction

    assign pick_idx    = pick_first(bus.req, ptr_q);
    assign holder_req  = |(bus.req & gnt_q);
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        to_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req != 10'd0) begin
                    state_d = StBusy;
                    gnt_d   = 10'd1 << pick_idx;
                    idx_d   = pick_idx;
                    cnt_d   = 8'd0;
                end
            end
            StBusy: begin
                if (bus.done || !holder_req || timeout_hit) begin
                    state_d = StGap;
                    gnt_d   = 10'd0;
                    idx_d   = 4'hF;
                    ptr_d   = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
                    // A coincident done takes precedence over the timeout.
                    to_d    = timeout_hit && !bus.done;
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 4'd0;
            cnt_q   <= 8'd0;
            gnt_q   <= 10'd0;
            idx_q   <= 4'hF;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.idx  = idx_q;
    assign bus.busy = (state_q == StBusy);
    assign bus.to   = to_q;

endmodule

// File: tb/tb_req_arbiter10.sv
// Bench for req_arbiter10: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of holder, age and pointer.
module tb_req_arbiter10;

    localparam int unsigned TO_CYCLES = 4;

    logic clk;
    logic rst;
    req_arbiter10_if bus ();

    req_arbiter10 #(.TIMEOUT(TO_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: who holds the resource, for how many cycles, and where
    // the next search starts.
    int m_holder = -1;
    int m_age    = 0;
    int m_ptr    = 0;
    bit m_gap    = 1'b0;
    bit m_to     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [9:0] q, input bit d);
        if (r) begin
            m_holder = -1;
            m_age    = 0;
            m_ptr    = 0;
            m_gap    = 1'b0;
            m_to     = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_holder < 0) begin
            for (int k = 0; k < 10; k++) begin
                int c;
                c = (m_ptr + k) % 10;
                if (m_holder < 0 && q[c]) m_holder = c;
            end
            if (m_holder >= 0) m_age = 1;
        end else begin
            bit tmo;
            tmo = (m_age == int'(TO_CYCLES));
            if (d || !q[m_holder] || tmo) begin
                m_to     = tmo && !d;
                m_ptr    = (m_holder + 1) % 10;
                m_holder = -1;
                m_gap    = 1'b1;
            end else begin
                m_age++;
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare all outputs just after it.
    task automatic tick();
        logic [9:0] eg;
        @(posedge clk);
        model_step(rst, bus.req, bus.done);
        #1;
        eg = (m_holder < 0) ? 10'd0 : (10'd1 << m_holder);
        check_eq("gnt", 32'(bus.gnt), 32'(eg));
        check_eq("idx", 32'(bus.idx), (m_holder < 0) ? 32'hF : 32'(m_holder));
        check_eq("busy", 32'(bus.busy), 32'(m_holder >= 0));
        check_eq("to", 32'(bus.to), 32'(m_to));
        check_eq("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        bus.done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    // Advance until a grant is held, bounded by a cycle budget.
    task automatic wait_grant(input string tag);
        for (int w = 0; w < 12 && !bus.busy; w++) tick();
        check_eq(tag, 32'(bus.busy), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = 10'd0;
        bus.done = 1'b0;
        tick();
        tick();
        check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
        check_eq("rst_idx", 32'(bus.idx), 32'hF);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("idle_idx", 32'(bus.idx), 32'hF);

        // Lowest pointer wins, then round-robin wrap.
        bus.req = 10'h201;
        tick();
        check_eq("first_gnt", 32'(bus.gnt), 32'h001);
        check_eq("first_idx", 32'(bus.idx), 32'd0);
        check_eq("first_busy", 32'(bus.busy), 32'd1);
        pulse_done();
        check_eq("gap_gnt", 32'(bus.gnt), 32'h0);
        check_eq("gap_idx", 32'(bus.idx), 32'hF);
        wait_grant("wait_g9");
        check_eq("rr_gnt9", 32'(bus.gnt), 32'h200);
        check_eq("rr_idx9", 32'(bus.idx), 32'd9);
        pulse_done();
        wait_grant("wait_wrap");
        check_eq("wrap_idx", 32'(bus.idx), 32'd0);

        // Timeout: grant held exactly TO_CYCLES cycles, then a to pulse.
        reset_dut();
        bus.req = 10'h008;
        tick();
        for (int i = 1; i < int'(TO_CYCLES); i++) begin
            check_eq("to_hold", 32'(bus.gnt), 32'h008);
            tick();
        end
        check_eq("to_last", 32'(bus.gnt), 32'h008);
        tick();
        check_eq("to_pulse", 32'(bus.to), 32'd1);
        check_eq("to_gap_gnt", 32'(bus.gnt), 32'h0);
        wait_grant("wait_regrant");
        check_eq("to_regrant", 32'(bus.idx), 32'd3);
        check_eq("to_cleared", 32'(bus.to), 32'd0);

        // done coincident with timeout suppresses the pulse.
        for (int i = 1; i < int'(TO_CYCLES); i++) tick();
        pulse_done();
        check_eq("done_vs_to", 32'(bus.to), 32'd0);
        bus.req = 10'h3FF;
        wait_grant("wait_ptr4");
        check_eq("ptr_adv", 32'(bus.idx), 32'd4);

        // Full rotation with all requesters active.
        reset_dut();
        bus.req = 10'h3FF;
        for (int k = 0; k < 11; k++) begin
            wait_grant("wait_rot");
            check_eq("rot_idx", 32'(bus.idx), 32'(k % 10));
            pulse_done();
        end

        // Reset mid-grant drops it without gap or to pulse.
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            wait_grant("wait_to5");
            if (k < 5) pulse_done();
        end
        check_eq("pre_rst_idx", 32'(bus.idx), 32'd5);
        rst = 1'b1;
        tick();
        check_eq("rst_mid_gnt", 32'(bus.gnt), 32'h0);
        check_eq("rst_mid_idx", 32'(bus.idx), 32'hF);
        check_eq("rst_mid_to", 32'(bus.to), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_idx", 32'(bus.idx), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 10'($urandom);
            if ($urandom_range(0, 15) == 0) bus.req = 10'd0;
            bus.done = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
